// File: rtl/load_store_unit.sv
// load_store_unit
//   Bridges the datapath to a word-wide data memory. Accepts one load/store
//   at a time, supports byte/half/word accesses (RISC-V funct3 encoding),
//   sign/zero-extends loads, and does read-modify-write for sb/sh because
//   the memory can only write whole 32-bit words. Misaligned or illegal
//   requests complete with err=1 and never touch memory.
//
// Ports
//   clk     in   clock, rising edge
//   rst     in   synchronous reset, active-low
//   req     in   request strobe, sampled only in IDLE
//   we      in   1 = store, 0 = load
//   funct3  in   000 b, 001 h, 010 w, 100 bu, 101 hu
//   addr    in   byte address
//   wdata   in   store data (low byte/half for sb/sh)
//   busy    out  high while not IDLE
//   done    out  one-cycle completion pulse
//   err     out  misaligned/illegal, valid with done
//   rdata   out  extended load result, held between loads
//   mem_A   out  word address (0 in IDLE)
//   mem_WD  out  write word (0 when mem_We=0)
//   mem_We  out  memory write enable
//   mem_RD  in   memory read data, combinational from mem_A
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_A,
  output logic [31:0]       mem_WD,
  output logic              mem_We,
  input  logic [31:0]       mem_RD
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  // Illegal encodings, stores of the unsigned-load encodings, and
  // misaligned half/word accesses.
  function automatic logic req_bad(input logic st, input logic [2:0] f3,
                                   input logic [1:0] lane);
    logic bad;
    case (f3)
      3'b000:  bad = 1'b0;
      3'b001:  bad = lane[0];
      3'b010:  bad = (lane != 2'b00);
      3'b100:  bad = st;
      3'b101:  bad = st | lane[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3,
                                               input logic [1:0] lane,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed lane of the previously read word; sw bypasses it.
  function automatic logic [31:0] store_merge(input logic [2:0] f3,
                                              input logic [1:0] lane,
                                              input logic [31:0] old,
                                              input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    case (f3)
      3'b000: r[{lane, 3'b000} +: 8] = wd[7:0];
      3'b001: begin
        if (lane[1]) r[31:16] = wd[15:0];
        else         r[15:0]  = wd[15:0];
      end
      default: r = wd;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          f3_d    = funct3;
          addr_d  = addr;
          wdata_d = wdata;
          err_d   = 1'b0;
          if (req_bad(we, funct3, addr[1:0])) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (we && funct3 == 3'b010) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        if (we_q) begin
          word_d  = mem_RD;
          state_d = S_WRITE;
        end else begin
          rdata_d = load_extract(f3_q, addr_q[1:0], mem_RD);
          state_d = S_DONE;
        end
      end
      S_WRITE: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      word_q  <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign done  = (state_q == S_DONE);
  assign err   = done & err_q;
  assign rdata = rdata_q;
  assign mem_A = (state_q == S_IDLE) ? '0 : {addr_q[ADDR_W-1:2], 2'b00};

  // Gated by rst so a reset landing on the WRITE cycle commits nothing.
  assign mem_We = (state_q == S_WRITE) & rst;
  assign mem_WD = mem_We ? store_merge(f3_q, addr_q[1:0], word_q, wdata_q) : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst, req, we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        busy, done, err, mem_We;
  logic [31:0] rdata, mem_A, mem_WD, mem_RD;

  // Word memory seen by the DUT
  logic [31:0] mem_w [64];
  logic        poke_en = 1'b0;
  logic [7:0]  poke_a = 8'd0;
  logic [31:0] poke_d = 32'd0;

  // Reference model: byte-addressed memory plus last load result
  logic [7:0]  ref_mem [256];
  logic [31:0] ref_rdata;

  int tests = 0;
  int fails = 0;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_We(mem_We), .mem_RD(mem_RD)
  );

  always #5 clk = ~clk;

  assign mem_RD = mem_w[mem_A[7:2]];

  always @(posedge clk) begin
    if (mem_We)  mem_w[mem_A[7:2]] <= mem_WD;
    if (poke_en) mem_w[poke_a[7:2]] <= poke_d;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    poke_en = 1'b1;
    poke_a  = a;
    poke_d  = d;
    for (int k = 0; k < 4; k++) ref_mem[{a[7:2], 2'b00} + k] = d[8*k +: 8];
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  function automatic logic [31:0] ref_word(input logic [7:0] a);
    logic [7:0] b;
    b = {a[7:2], 2'b00};
    return {ref_mem[b + 3], ref_mem[b + 2], ref_mem[b + 1], ref_mem[b]};
  endfunction

  // One transaction: model predicts outcome, then drive and observe.
  task automatic xact(input logic w, input logic [2:0] f3, input logic [7:0] a,
                      input logic [31:0] wd, input bit hold);
    bit          bad;
    int          n, exp_lat, exp_wecyc, got_lat, we_cnt, we_cyc, cyc;
    logic [31:0] val, exp_wd, got_err;
    bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (w && (f3 == 3'd4 || f3 == 3'd5))
          || ((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'd0);
    n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    exp_wd = 32'd0;
    exp_wecyc = 0;
    if (bad) begin
      exp_lat = 1;
    end else if (!w) begin
      exp_lat = 2;
      val = 32'd0;
      for (int k = 0; k < n; k++) val = val | (32'(ref_mem[a + k]) << (8 * k));
      if (f3 == 3'd0 && val[7])  val = val | 32'hFFFF_FF00;
      if (f3 == 3'd1 && val[15]) val = val | 32'hFFFF_0000;
      ref_rdata = val;
    end else begin
      for (int k = 0; k < n; k++) ref_mem[a + k] = wd[8*k +: 8];
      exp_wd    = ref_word(a);
      exp_lat   = (f3 == 3'd2) ? 2 : 3;
      exp_wecyc = exp_lat - 1;
    end

    chk("idle_busy", {31'd0, busy}, 32'd0);
    we = w; funct3 = f3; addr = {24'd0, a}; wdata = wd; req = 1'b1;
    @(posedge clk); #1;
    if (!hold) req = 1'b0;
    cyc = 1; got_lat = 0; we_cnt = 0; we_cyc = 0; got_err = 32'hX;
    while (cyc <= 6) begin
      if (hold) begin
        we = 1'($urandom); funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
      end
      if (mem_We) begin
        we_cnt++; we_cyc = cyc;
        chk("mem_WD", mem_WD, exp_wd);
      end else begin
        chk("mem_WD_idle", mem_WD, 32'd0);
      end
      chk("mem_A", mem_A, {24'd0, a[7:2], 2'b00});
      if (done) begin
        got_lat = cyc;
        got_err = {31'd0, err};
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    req = 1'b0;
    chk("latency", got_lat, exp_lat);
    chk("err", got_err, {31'd0, bad});
    chk("we_count", we_cnt, (exp_wecyc != 0) ? 1 : 0);
    chk("we_cycle", we_cyc, exp_wecyc);
    chk("rdata", rdata, ref_rdata);
    chk("mem_word", mem_w[a[7:2]], ref_word(a));
    @(posedge clk); #1;
    chk("back_idle", {30'd0, busy, done}, 32'd0);
    chk("idle_mem_A", mem_A, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        rw;
    logic [2:0]  rf;
    logic [7:0]  ra;

    // Reset held with a request pending
    rst = 1'b0; req = 1'b1; we = 1'b1; funct3 = 3'd2; addr = 32'd100; wdata = 32'hDEAD_BEEF;
    ref_rdata = 32'd0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_mem_We", {31'd0, mem_We}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_A", mem_A, 32'd0);
    req = 1'b0;
    for (int i = 0; i < 64; i++) poke(8'(i * 4), $urandom);
    rst = 1'b1;
    @(posedge clk); #1;

    // sw / lw
    xact(1'b1, 3'd2, 8'd100, 32'h0000_0011, 1'b0);
    xact(1'b0, 3'd2, 8'd100, 32'd0, 1'b0);
    chk("lw100", rdata, 32'h0000_0011);

    // sb read-modify-write and byte loads
    poke(8'd100, 32'hAABB_CCDD);
    xact(1'b1, 3'd0, 8'd101, 32'h0000_0055, 1'b0);
    chk("sb_word", mem_w[25], 32'hAABB_55DD);
    xact(1'b0, 3'd0, 8'd103, 32'd0, 1'b0);
    chk("lb103", rdata, 32'hFFFF_FFAA);
    xact(1'b0, 3'd4, 8'd103, 32'd0, 1'b0);
    chk("lbu103", rdata, 32'h0000_00AA);

    // sh and half loads
    xact(1'b1, 3'd1, 8'd102, 32'h0000_8001, 1'b0);
    chk("sh_word", mem_w[25], 32'h8001_55DD);
    xact(1'b0, 3'd1, 8'd102, 32'd0, 1'b0);
    chk("lh102", rdata, 32'hFFFF_8001);
    xact(1'b0, 3'd5, 8'd102, 32'd0, 1'b0);
    chk("lhu102", rdata, 32'h0000_8001);

    // Error cases: rdata must stay at 00008001
    xact(1'b0, 3'd2, 8'd102, 32'd0, 1'b0);
    xact(1'b1, 3'd1, 8'd101, 32'h1234_5678, 1'b0);
    xact(1'b1, 3'd4, 8'd100, 32'h1234_5678, 1'b0);
    xact(1'b0, 3'd3, 8'd100, 32'd0, 1'b0);
    chk("err_rdata_held", rdata, 32'h0000_8001);

    // Reset landing on the WRITE cycle of an sw
    poke(8'd100, 32'h0BAD_F00D);
    we = 1'b1; funct3 = 3'd2; addr = 32'd100; wdata = 32'h1111_2222; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    chk("wr_we_before_rst", {31'd0, mem_We}, 32'd1);
    rst = 1'b0;
    #1;
    chk("wr_we_gated", {31'd0, mem_We}, 32'd0);
    @(posedge clk); #1;
    chk("rst_wr_busy", {31'd0, busy}, 32'd0);
    chk("rst_wr_done", {31'd0, done}, 32'd0);
    rst = 1'b1;
    ref_rdata = 32'd0;
    chk("rst_wr_rdata", rdata, 32'd0);
    xact(1'b0, 3'd2, 8'd100, 32'd0, 1'b0);
    chk("rst_wr_readback", rdata, 32'h0BAD_F00D);

    // req held and inputs scrambled while busy
    xact(1'b1, 3'd0, 8'd42, 32'h0000_00C3, 1'b1);
    xact(1'b0, 3'd1, 8'd66, 32'd0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      rw = 1'($urandom);
      rf = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 5)) : 3'($urandom);
      if (rf == 3'd3) rf = 3'd2;
      ra = 8'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        if (rf[1:0] == 2'd1) ra[0] = 1'b0;
        if (rf == 3'd2) ra[1:0] = 2'd0;
      end
      xact(rw, rf, ra, $urandom, (i % 7) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
